// File: rtl/calc_ctrl.sv
// Two-operand add/subtract calculator controller driven by active-low push buttons.
// Optional per-button debounce filter is enabled with the CALC_CTRL_DEBOUNCE_EN macro.
module calc_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       plus,
  input  logic       minus,
  input  logic       equal,
  output logic       operation,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [8:0] result,
  output logic       result_valid,
  output logic       neg,
  output logic [7:0] seg_in
);

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StOpndB, StResult} state_e;

  // Button order in all vectors: {equal, minus, plus}.
  logic [2:0] btn;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] lvl, lvl_prev_q;
  logic [2:0] armed_q;
  logic [2:0] press;
  logic [1:0] settle_q;

  assign btn = {equal, minus, plus};

  // A button only arms once a genuine released sample has passed the synchronizer after
  // reset, so a button held through reset never produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      lvl_prev_q <= '1;
      armed_q    <= '0;
      settle_q   <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
      settle_q   <= {settle_q[0], 1'b1};
      if (settle_q[1]) begin
        armed_q <= armed_q | sync2_q;
      end
    end
  end

`ifdef CALC_CTRL_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0]      filt_q;
  logic [CntW-1:0] cnt_q [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '1;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign press = lvl_prev_q & ~lvl & armed_q;

  logic ev_eq, ev_mi, ev_pl;
  assign ev_eq = press[2];
  assign ev_mi = press[1] & ~press[2];
  assign ev_pl = press[0] & ~press[1] & ~press[2];

  state_e     state_q, state_d;
  logic       operation_q, operation_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [8:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       neg_q, neg_d;
  logic [7:0] alu_a;
  logic [8:0] alu;

  // In RESULT the previous result becomes the left operand of a chained computation.
  assign alu_a = (state_q == StResult) ? result_q[7:0] : op_a_q;
  assign alu   = operation_q ? ({1'b0, alu_a} - {1'b0, in}) : ({1'b0, alu_a} + {1'b0, in});

  always_comb begin
    state_d     = state_q;
    operation_d = operation_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    neg_d       = neg_q;
    case (state_q)
      StIdle: begin
        if (ev_mi || ev_pl) begin
          op_a_d      = in;
          operation_d = ev_mi;
          state_d     = StOpndB;
        end
      end
      StOpndB: begin
        if (ev_eq) begin
          op_b_d   = in;
          result_d = alu;
          valid_d  = 1'b1;
          neg_d    = operation_q & alu[8];
          state_d  = StResult;
        end else if (ev_mi || ev_pl) begin
          operation_d = ev_mi;
        end
      end
      StResult: begin
        if (ev_eq) begin
          op_a_d   = result_q[7:0];
          op_b_d   = in;
          result_d = alu;
          valid_d  = 1'b1;
          neg_d    = operation_q & alu[8];
        end else if (ev_mi || ev_pl) begin
          op_a_d      = result_q[7:0];
          operation_d = ev_mi;
          state_d     = StOpndB;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      operation_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      operation_q <= operation_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      neg_q       <= neg_d;
    end
  end

  assign operation    = operation_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign neg          = neg_q;
  assign seg_in       = (state_q == StResult) ? result_q[7:0] : in;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed self-checking bench for calc_ctrl; honours CALC_CTRL_DEBOUNCE_EN for latency
// and glitch-rejection steps.
module tb_calc_ctrl;

`ifdef CALC_CTRL_DEBOUNCE_EN
  localparam int Lat = 7;
`else
  localparam int Lat = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in = 8'd0;
  logic       plus = 1'b1;
  logic       minus = 1'b1;
  logic       equal = 1'b1;
  logic       operation;
  logic [7:0] op_a, op_b, seg_in;
  logic [8:0] result;
  logic       result_valid, neg;

  int   total = 0;
  int   bad = 0;
  int   valid_cnt = 0;
  logic valid_prev = 1'b0;
  logic valid_long = 1'b0;

  calc_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .plus         (plus),
    .minus        (minus),
    .equal        (equal),
    .operation    (operation),
    .op_a         (op_a),
    .op_b         (op_b),
    .result       (result),
    .result_valid (result_valid),
    .neg          (neg),
    .seg_in       (seg_in)
  );

  always #5 clk = ~clk;

  // Counts result_valid pulses and flags any pulse wider than one cycle.
  always @(negedge clk) begin
    if (result_valid) valid_cnt <= valid_cnt + 1;
    if (result_valid && valid_prev) valid_long <= 1'b1;
    valid_prev <= result_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic p, input logic m, input logic e, input int hold);
    @(negedge clk);
    plus  = ~p;
    minus = ~m;
    equal = ~e;
    wait_cyc(hold);
    plus  = 1'b1;
    minus = 1'b1;
    equal = 1'b1;
    wait_cyc(14);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(6);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_operation", 32'(operation), 0);
    check("rst_op_a", 32'(op_a), 0);
    check("rst_op_b", 32'(op_b), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_neg", 32'(neg), 0);
    check("rst_seg", 32'(seg_in), 0);
    rst = 1'b0;
    wait_cyc(6);

    // Press latency from the first low sample, then basic 15 + 2.
    in = 8'd15;
    @(negedge clk);
    plus = 1'b0;
    wait_cyc(Lat - 1);
    check("lat_before", 32'(op_a), 0);
    wait_cyc(1);
    check("lat_after", 32'(op_a), 15);
    wait_cyc(6);
    plus = 1'b1;
    wait_cyc(14);
    check("add_operation", 32'(operation), 0);
    check("add_seg_opnd", 32'(seg_in), 15);
    check("add_no_valid_yet", 32'(valid_cnt), 0);
    in = 8'd2;
    press(1'b0, 1'b0, 1'b1, 10);
    check("add_result", 32'(result), 17);
    check("add_op_b", 32'(op_b), 2);
    check("add_seg_result", 32'(seg_in), 17);
    check("add_neg", 32'(neg), 0);
    check("add_valid_cnt", 32'(valid_cnt), 1);

    // Chaining: 7 + 3 = 10, = +8 -> 18, -2 -> 16, -1 -> 15.
    do_reset();
    check("chain_rst_result", 32'(result), 0);
    in = 8'd7;
    press(1'b1, 1'b0, 1'b0, 10);
    in = 8'd3;
    press(1'b0, 1'b0, 1'b1, 10);
    check("chain_10", 32'(result), 10);
    in = 8'd8;
    press(1'b0, 1'b0, 1'b1, 10);
    check("chain_18", 32'(result), 18);
    check("chain_18_op_a", 32'(op_a), 10);
    in = 8'd2;
    press(1'b0, 1'b1, 1'b0, 10);
    check("chain_minus_operation", 32'(operation), 1);
    check("chain_minus_op_a", 32'(op_a), 18);
    check("chain_minus_seg", 32'(seg_in), 2);
    press(1'b0, 1'b0, 1'b1, 10);
    check("chain_16", 32'(result), 16);
    in = 8'd1;
    press(1'b0, 1'b1, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    check("chain_15", 32'(result), 15);
    check("chain_neg", 32'(neg), 0);
    check("chain_valid_cnt", 32'(valid_cnt), 5);

    // Borrow: 3 - 5.
    do_reset();
    in = 8'd3;
    press(1'b0, 1'b1, 1'b0, 10);
    in = 8'd5;
    press(1'b0, 1'b0, 1'b1, 10);
    check("borrow_result", 32'(result), 32'h1FE);
    check("borrow_neg", 32'(neg), 1);
    check("borrow_seg", 32'(seg_in), 32'hFE);

    // Carry: 200 + 100.
    do_reset();
    in = 8'd200;
    press(1'b1, 1'b0, 1'b0, 10);
    in = 8'd100;
    press(1'b0, 1'b0, 1'b1, 10);
    check("carry_result", 32'(result), 32'h12C);
    check("carry_neg", 32'(neg), 0);
    check("carry_seg", 32'(seg_in), 32'h2C);
    check("carry_valid_cnt", 32'(valid_cnt), 7);

    // Priority: plus and equal together in OPND_B, then equal held 20 cycles.
    do_reset();
    in = 8'd10;
    press(1'b0, 1'b1, 1'b0, 10);
    in = 8'd4;
    press(1'b1, 1'b0, 1'b1, 10);
    check("prio_result", 32'(result), 6);
    check("prio_operation", 32'(operation), 1);
    check("prio_op_b", 32'(op_b), 4);
    check("prio_valid_cnt", 32'(valid_cnt), 8);
    in = 8'd1;
    press(1'b0, 1'b0, 1'b1, 20);
    check("hold_result", 32'(result), 5);
    check("hold_op_a", 32'(op_a), 6);
    check("hold_valid_cnt", 32'(valid_cnt), 9);
    check("valid_one_cycle", 32'(valid_long), 0);

    // Reset in OPND_B with equal held through reset and beyond.
    do_reset();
    in = 8'd9;
    press(1'b1, 1'b0, 1'b0, 10);
    check("rstop_op_a_before", 32'(op_a), 9);
    @(negedge clk);
    equal = 1'b0;
    rst   = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(20);
    check("rstop_op_a", 32'(op_a), 0);
    check("rstop_operation", 32'(operation), 0);
    check("rstop_op_b", 32'(op_b), 0);
    check("rstop_result", 32'(result), 0);
    check("rstop_neg", 32'(neg), 0);
    check("rstop_seg", 32'(seg_in), 9);
    check("rstop_no_event", 32'(valid_cnt), 9);
    equal = 1'b1;
    wait_cyc(14);
    press(1'b0, 1'b0, 1'b1, 10);
    check("idle_equal_ignored", 32'(valid_cnt), 9);
    check("idle_equal_result", 32'(result), 0);
    in = 8'd5;
    press(1'b1, 1'b0, 1'b0, 10);
    check("post_rst_op_a", 32'(op_a), 5);

`ifdef CALC_CTRL_DEBOUNCE_EN
    // Two-cycle glitch must be filtered out.
    do_reset();
    in = 8'd77;
    press(1'b1, 1'b0, 1'b0, 2);
    check("glitch_op_a", 32'(op_a), 0);
    check("glitch_seg", 32'(seg_in), 77);
    in = 8'd3;
    press(1'b0, 1'b0, 1'b1, 10);
    check("glitch_still_idle", 32'(valid_cnt), 9);
`endif

    wait_cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
